// File: rtl/led_breath_pwm.sv
// led_breath_pwm
//   LED driver that turns the square-wave request from the blink stage into a
//   linear fade in / fade out. A prescaler paces the brightness ramp, a small
//   FSM walks the brightness level between 0 and full scale, and a free-running
//   PWM counter converts the level into a registered duty-cycled LED drive.
module led_breath_pwm #(
  parameter int PWM_BITS = 8,
  parameter int STEP_DIV = 4096
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                BLINK_IN,
  input  logic                EN,
  output logic                LED,
  output logic [PWM_BITS-1:0] LEVEL,
  output logic                BUSY
);

  // Prescaler needs at least one bit even when every clock is a step.
  localparam int PRESC_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [PWM_BITS-1:0] LVL_MAX    = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] LVL_ZERO   = {PWM_BITS{1'b0}};
  localparam logic [PWM_BITS-1:0] LVL_ONE    = PWM_BITS'(1);
  localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(STEP_DIV - 1);
  localparam logic [PRESC_W-1:0]  PRESC_ONE  = PRESC_W'(1);
  localparam logic [PRESC_W-1:0]  PRESC_ZERO = {PRESC_W{1'b0}};

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_UP   = 2'd1,
    ST_ON   = 2'd2,
    ST_DOWN = 2'd3
  } state_t;

  state_t                state_q,   state_d;
  logic [PWM_BITS-1:0]   level_q,   level_d;
  logic [PRESC_W-1:0]    presc_q,   presc_d;
  logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic                  req_q;
  logic                  busy_q,    busy_d;
  logic                  led_q,     led_d;
  logic                  tick_s;

  // Single-flop capture of the request level; the FSM only ever looks at req_q.
  always_ff @(posedge CLK) begin
    if (RST) begin
      req_q <= 1'b0;
    end else begin
      req_q <= BLINK_IN;
    end
  end

  // Prescaler next value: count 0..STEP_DIV-1 and wrap; tick marks the last count.
  always_comb begin
    tick_s  = 1'b0;
    presc_d = presc_q;
    if (presc_q == PRESC_LAST) begin
      tick_s  = 1'b1;
      presc_d = PRESC_ZERO;
    end else begin
      tick_s  = 1'b0;
      presc_d = presc_q + PRESC_ONE;
    end
  end

  // Prescaler register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      presc_q <= PRESC_ZERO;
    end else begin
      presc_q <= presc_d;
    end
  end

  // Ramp FSM next state and level; a direction reversal takes priority over a
  // tick so the level holds for that cycle instead of stepping the old way.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    case (state_q)
      ST_OFF: begin
        level_d = LVL_ZERO;
        if (req_q) begin
          state_d = ST_UP;
        end else begin
          state_d = ST_OFF;
        end
      end
      ST_UP: begin
        if (!req_q) begin
          state_d = ST_DOWN;
        end else if (tick_s) begin
          level_d = level_q + LVL_ONE;
          if (level_d == LVL_MAX) begin
            state_d = ST_ON;
          end else begin
            state_d = ST_UP;
          end
        end else begin
          state_d = ST_UP;
        end
      end
      ST_ON: begin
        level_d = LVL_MAX;
        if (!req_q) begin
          state_d = ST_DOWN;
        end else begin
          state_d = ST_ON;
        end
      end
      ST_DOWN: begin
        if (req_q) begin
          state_d = ST_UP;
        end else if (tick_s) begin
          level_d = level_q - LVL_ONE;
          if (level_d == LVL_ZERO) begin
            state_d = ST_OFF;
          end else begin
            state_d = ST_DOWN;
          end
        end else begin
          state_d = ST_DOWN;
        end
      end
      default: begin
        state_d = ST_OFF;
        level_d = LVL_ZERO;
      end
    endcase
    busy_d = (state_d == ST_UP) || (state_d == ST_DOWN);
  end

  // FSM, level and busy registers; busy is updated on the same edge as the state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_OFF;
      level_q <= LVL_ZERO;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      busy_q  <= busy_d;
    end
  end

  // PWM compare: full scale is forced to 100% duty since the counter never exceeds MAX.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + LVL_ONE;
    led_d     = EN & ((level_q == LVL_MAX) | (pwm_cnt_q < level_q));
  end

  // PWM counter and registered LED drive.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pwm_cnt_q <= LVL_ZERO;
      led_q     <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      led_q     <= led_d;
    end
  end

  assign LED   = led_q;
  assign LEVEL = level_q;
  assign BUSY  = busy_q;

endmodule

// File: tb/tb_led_breath_pwm.sv
// tb_led_breath_pwm
//   Directed bench for led_breath_pwm. A fast instance (PWM_BITS=4, STEP_DIV=2)
//   covers reset, fades, reversal and enable/reset mid-ramp; a slow instance
//   (STEP_DIV=1000) holds a mid-ramp level long enough to measure PWM duty.
module tb_led_breath_pwm;

  logic       clk;
  logic       rst;
  logic       blink;
  logic       en;
  logic       led;
  logic [3:0] level;
  logic       busy;

  logic       blink2;
  logic       led2;
  logic [3:0] level2;
  logic       busy2;

  int n_checks;
  int n_fail;

  led_breath_pwm #(.PWM_BITS(4), .STEP_DIV(2)) dut (
    .CLK(clk), .RST(rst), .BLINK_IN(blink), .EN(en),
    .LED(led), .LEVEL(level), .BUSY(busy)
  );

  led_breath_pwm #(.PWM_BITS(4), .STEP_DIV(1000)) dut_slow (
    .CLK(clk), .RST(rst), .BLINK_IN(blink2), .EN(en),
    .LED(led2), .LEVEL(level2), .BUSY(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt;
    int prev;
    int jump;
    int maxl;
    int highs;

    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    blink    = 1'b1;
    blink2   = 1'b0;
    en       = 1'b1;

    // 1 Reset held with request and enable high
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("rst_led",   led,   0);
      check_eq("rst_level", level, 0);
      check_eq("rst_busy",  busy,  0);
    end
    blink = 1'b0;
    rst   = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check_eq("idle_level", level, 0);
    check_eq("idle_led",   led,   0);

    // 2 Fade in
    blink = 1'b1;
    step();
    check_eq("fadein_busy_edge1", busy, 0);
    step();
    check_eq("fadein_busy_edge2", busy, 1);
    cnt = 0; jump = 0; prev = int'(level);
    while (level != 4'd15 && cnt < 40) begin
      step();
      cnt++;
      if (int'(level) - prev > 1 || int'(level) < prev) jump = 1;
      prev = int'(level);
    end
    check_eq("fadein_time", (cnt >= 29 && cnt <= 31) ? 1 : 0, 1);
    check_eq("fadein_steps", jump, 0);
    check_eq("fadein_busy_done", busy, 0);
    step(); step();
    highs = 0;
    for (int i = 0; i < 16; i++) begin step(); highs += int'(led); end
    check_eq("on_led_highs", highs, 16);

    // EN drop and restore while fully on
    en = 1'b0;
    step();
    check_eq("en_off_led", led, 0);
    check_eq("en_off_level", level, 15);
    en = 1'b1;
    step();
    check_eq("en_on_led", led, 1);

    // 3 Fade out
    blink = 1'b0;
    step(); step();
    check_eq("fadeout_busy", busy, 1);
    cnt = 0; jump = 0; prev = int'(level);
    while (level != 4'd0 && cnt < 40) begin
      step();
      cnt++;
      if (prev - int'(level) > 1 || int'(level) > prev) jump = 1;
      prev = int'(level);
    end
    check_eq("fadeout_time", (cnt >= 29 && cnt <= 31) ? 1 : 0, 1);
    check_eq("fadeout_steps", jump, 0);
    check_eq("fadeout_busy_done", busy, 0);
    step(); step();
    highs = 0;
    for (int i = 0; i < 16; i++) begin step(); highs += int'(led); end
    check_eq("off_led_highs", highs, 0);

    // 4 Reversal at level 6
    blink = 1'b1;
    cnt = 0;
    while (level != 4'd6 && cnt < 30) begin step(); cnt++; end
    check_eq("rev_reach6", level, 6);
    blink = 1'b0;
    cnt = 0; jump = 0; maxl = 6; prev = 6;
    while (level != 4'd0 && cnt < 60) begin
      step();
      cnt++;
      if (int'(level) > maxl) maxl = int'(level);
      if (prev - int'(level) > 1 || int'(level) > prev) jump = 1;
      prev = int'(level);
    end
    check_eq("rev_max", maxl, 6);
    check_eq("rev_steps", jump, 0);
    check_eq("rev_reach0", level, 0);

    // 5 Duty at level 4 on the slow instance
    blink2 = 1'b1;
    cnt = 0;
    while (level2 != 4'd4 && cnt < 6000) begin step(); cnt++; end
    check_eq("duty_reach4", level2, 4);
    blink2 = 1'b0;
    step(); step();
    for (int w = 0; w < 2; w++) begin
      highs = 0;
      for (int i = 0; i < 16; i++) begin step(); highs += int'(led2); end
      check_eq("duty_window", highs, 4);
    end
    check_eq("duty_level_held", level2, 4);

    // 6 EN drop at level 8, reset at level 10
    blink = 1'b1;
    cnt = 0;
    while (level != 4'd8 && cnt < 30) begin step(); cnt++; end
    check_eq("mid_reach8", level, 8);
    en = 1'b0;
    step();
    check_eq("mid_en_led", led, 0);
    highs = 0; cnt = 0;
    while (level != 4'd10 && cnt < 10) begin step(); cnt++; highs += int'(led); end
    check_eq("mid_ramp_continues", level, 10);
    check_eq("mid_en_led_highs", highs, 0);
    rst = 1'b1;
    en  = 1'b1;
    step();
    check_eq("mid_rst_level", level, 0);
    check_eq("mid_rst_busy",  busy,  0);
    check_eq("mid_rst_led",   led,   0);
    check_eq("mid_rst_level_slow", level2, 0);
    rst = 1'b0;
    step();
    check_eq("post_rst_led",   led,   0);
    check_eq("post_rst_level", level, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
